// File: rtl/prsg_lfsr_param.sv
// Parameterised Fibonacci LFSR pseudo-random sequence generator with a
// valid/ready output handshake, seed loading and period detection.
module prsg_lfsr_param #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] rnd_out,
  output logic [WIDTH-1:0] step_cnt,
  output logic             period_done
);

  // Reject illegal parameterisations at elaboration time
  if ((WIDTH < 3) || (WIDTH > 32) || (TAPS[WIDTH-1] == 1'b0) ||
      (RESET_SEED == '0)) begin : g_param_check
    $error("prsg_lfsr_param: illegal WIDTH, TAPS or RESET_SEED");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             fb_c;
  logic [WIDTH-1:0] lfsr_nxt_c;
  logic [WIDTH-1:0] seed_eff_c;
  logic             advance_c;

  // Next-state, feedback, handshake and seed/period bookkeeping
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    seed_d     = seed_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;

    fb_c       = ^(rnd_q & TAPS);
    lfsr_nxt_c = {rnd_q[WIDTH-2:0], fb_c};
    // An all-zero seed would lock the LFSR, so it is replaced by 1
    seed_eff_c = (seed == '0) ? WIDTH'(1) : seed;
    // A load swallows any coincident handshake
    advance_c  = (state_q == ST_RUN) && out_ready && !load;

    unique case (state_q)
      ST_IDLE: if (en)  state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      rnd_d  = seed_eff_c;
      seed_d = seed_eff_c;
      cnt_d  = '0;
    end else if (advance_c) begin
      rnd_d = lfsr_nxt_c;
      if (lfsr_nxt_c == seed_q) begin
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= RESET_SEED;
      seed_q  <= RESET_SEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign out_valid   = (state_q == ST_RUN);
  assign rnd_out     = rnd_q;
  assign step_cnt    = cnt_q;
  assign period_done = done_q;

endmodule

// File: tb/tb_prsg_lfsr_param.sv
// Self-checking bench for prsg_lfsr_param (WIDTH=8, TAPS=8'hB8).
module tb_prsg_lfsr_param;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] seed = '0;
  logic         en = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] rnd_out;
  logic [W-1:0] step_cnt;
  logic         period_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit       m_valid;
  int       m_rnd;
  int       m_seed;
  int       m_cnt;
  bit       m_done;

  prsg_lfsr_param #(
    .WIDTH(W),
    .TAPS(8'hB8),
    .RESET_SEED(8'h01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .seed(seed),
    .en(en),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .rnd_out(rnd_out),
    .step_cnt(step_cnt),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  // Next word: double the value modulo 256 and add the parity of tapped bits
  function automatic int lfsr_next(input int s);
    logic [7:0] sv;
    sv = 8'(s);
    return ((s * 2) % 256) + ($countones(sv & 8'hB8) % 2);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_rnd   = 1;
    m_seed  = 1;
    m_cnt   = 0;
    m_done  = 1'b0;
  endtask

  // One clock edge, then update the model with the inputs seen at that edge
  task automatic tick();
    bit adv;
    @(posedge clk);
    #1;
    adv    = m_valid && out_ready && !load;
    m_done = 1'b0;
    if (load) begin
      m_rnd  = (seed == 8'h00) ? 1 : int'(seed);
      m_seed = m_rnd;
      m_cnt  = 0;
    end else if (adv) begin
      m_rnd = lfsr_next(m_rnd);
      if (m_rnd == m_seed) begin
        m_done = 1'b1;
        m_cnt  = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    m_valid = en;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load = 1'b0; en = 1'b0; out_ready = 1'b0; seed = '0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (rnd_out !== 8'h01) begin
      n_errors++; $display("FAIL reset_rnd: got %h expected 01", rnd_out);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (step_cnt !== 8'h00) begin
      n_errors++; $display("FAIL reset_cnt: got %0d expected 0", step_cnt);
    end
    n_checks++;
    if (period_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_done: got %b expected 0", period_done);
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    logic [7:0] exp_seq [6];
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || rnd_out !== exp_seq[i] || step_cnt !== 8'(i)) begin
        n_errors++;
        $display("FAIL seq_%0d: got valid=%b rnd=%h cnt=%0d expected valid=1 rnd=%h cnt=%0d",
                 i, out_valid, rnd_out, step_cnt, exp_seq[i], i);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_full_period();
    bit seen [256];
    int pulses;
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    tick();
    pulses = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (period_done === 1'b1) pulses++;
      n_checks++;
      if (rnd_out !== 8'(m_rnd) || step_cnt !== 8'(m_cnt)) begin
        n_errors++;
        $display("FAIL period_step_%0d: got rnd=%h cnt=%0d expected rnd=%h cnt=%0d",
                 k, rnd_out, step_cnt, 8'(m_rnd), m_cnt);
      end
      if (k < 255) begin
        n_checks++;
        if (seen[rnd_out] || period_done !== 1'b0) begin
          n_errors++;
          $display("FAIL period_unique_%0d: got rnd=%h done=%b expected unseen value, done=0",
                   k, rnd_out, period_done);
        end
        seen[rnd_out] = 1'b1;
      end
      if (k == 254) begin
        n_checks++;
        if (step_cnt !== 8'd254) begin
          n_errors++; $display("FAIL period_cnt_max: got %0d expected 254", step_cnt);
        end
      end
    end
    n_checks++;
    if (rnd_out !== 8'h01 || step_cnt !== 8'd0 || period_done !== 1'b1) begin
      n_errors++;
      $display("FAIL period_wrap: got rnd=%h cnt=%0d done=%b expected rnd=01 cnt=0 done=1",
               rnd_out, step_cnt, period_done);
    end
    tick();
    if (period_done === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1) begin
      n_errors++; $display("FAIL period_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_stall();
    logic [7:0] frz_rnd;
    logic [7:0] frz_cnt;
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    tick();
    frz_rnd = rnd_out;
    frz_cnt = step_cnt;
    n_checks++;
    if (frz_rnd !== 8'(m_rnd) || frz_cnt !== 8'(m_cnt)) begin
      n_errors++;
      $display("FAIL stall_entry: got rnd=%h cnt=%0d expected rnd=%h cnt=%0d",
               frz_rnd, frz_cnt, 8'(m_rnd), m_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (rnd_out !== frz_rnd || step_cnt !== frz_cnt || out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL stall_hold_%0d: got rnd=%h cnt=%0d valid=%b expected rnd=%h cnt=%0d valid=1",
                 i, rnd_out, step_cnt, out_valid, frz_rnd, frz_cnt);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (rnd_out !== 8'(lfsr_next(int'(frz_rnd))) || step_cnt !== frz_cnt + 8'd1) begin
      n_errors++;
      $display("FAIL stall_resume: got rnd=%h cnt=%0d expected rnd=%h cnt=%0d",
               rnd_out, step_cnt, 8'(lfsr_next(int'(frz_rnd))), frz_cnt + 8'd1);
    end
  endtask

  task automatic test_load();
    int pulses;
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    load = 1'b1; seed = 8'h00;
    tick();
    n_checks++;
    if (rnd_out !== 8'h01 || step_cnt !== 8'd0 || period_done !== 1'b0) begin
      n_errors++;
      $display("FAIL load_zero: got rnd=%h cnt=%0d done=%b expected rnd=01 cnt=0 done=0",
               rnd_out, step_cnt, period_done);
    end
    seed = 8'h5A;
    tick();
    load = 1'b0;
    n_checks++;
    if (rnd_out !== 8'h5A || step_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL load_5a: got rnd=%h cnt=%0d expected rnd=5a cnt=0", rnd_out, step_cnt);
    end
    pulses = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (period_done === 1'b1) pulses++;
      if (k == 255) begin
        n_checks++;
        if (rnd_out !== 8'h5A || period_done !== 1'b1 || step_cnt !== 8'd0) begin
          n_errors++;
          $display("FAIL load_period: got rnd=%h done=%b cnt=%0d expected rnd=5a done=1 cnt=0",
                   rnd_out, period_done, step_cnt);
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++; $display("FAIL load_pulses: got %0d expected 1", pulses);
    end
    // Load while idle must not start the generator
    en = 1'b0;
    tick();
    load = 1'b1; seed = 8'h33;
    tick();
    load = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || rnd_out !== 8'h33 || step_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL load_idle: got valid=%b rnd=%h cnt=%0d expected valid=0 rnd=33 cnt=0",
               out_valid, rnd_out, step_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    en  = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rnd_out !== 8'h01 || out_valid !== 1'b0 || step_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL midrun_reset: got rnd=%h valid=%b cnt=%0d expected rnd=01 valid=0 cnt=0",
               rnd_out, out_valid, step_cnt);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || rnd_out !== 8'h01) begin
        n_errors++;
        $display("FAIL midrun_idle_%0d: got valid=%b rnd=%h expected valid=0 rnd=01",
                 i, out_valid, rnd_out);
      end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || rnd_out !== 8'h01) begin
      n_errors++;
      $display("FAIL midrun_restart: got valid=%b rnd=%h expected valid=1 rnd=01",
               out_valid, rnd_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      load      = ($urandom_range(0, 19) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick();
      n_checks++;
      if (out_valid !== m_valid || rnd_out !== 8'(m_rnd) ||
          step_cnt !== 8'(m_cnt) || period_done !== m_done) begin
        n_errors++;
        $display("FAIL random_%0d: got valid=%b rnd=%h cnt=%0d done=%b expected valid=%b rnd=%h cnt=%0d done=%b",
                 i, out_valid, rnd_out, step_cnt, period_done,
                 m_valid, 8'(m_rnd), m_cnt, m_done);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_full_period();
    test_stall();
    test_load();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
